cios_beta_seq: RTL

- Per-outer-iteration reduction-factor stage of the CIOS Montgomery multiplier pipeline. Sits directly upstream of the gamma word stage.
- Captures T[0] and n' for iteration i and computes m = (T[0] * n') mod 2^WIDTH.
- Holds m stable and sequences the word index j = 0..NWORDS-1, driving the gamma stage's enable one word per cycle.
- Supports downstream stall and signals completion.

---
 rtl/cios_beta_seq.sv | 109 ++++++++++
 1 files changed

// File: rtl/cios_beta_seq.sv
// CIOS Montgomery reduction-factor stage.
// Captures T[0] and n' for one outer iteration, forms m = T[0]*n' mod 2^WIDTH,
// then holds m and walks the word index j across all NWORDS words, issuing one
// word per unstalled cycle to the gamma stage.
module cios_beta_seq #(
  parameter int WIDTH  = 32,
  parameter int NWORDS = 8,
  parameter int IDX_W  = (NWORDS > 1) ? $clog2(NWORDS) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] t0_in,
  input  logic [WIDTH-1:0] n_prime,
  input  logic             stall,
  output logic             busy,
  output logic [WIDTH-1:0] m_out,
  output logic             m_valid,
  output logic [IDX_W-1:0] j_idx,
  output logic             en_out,
  output logic             last,
  output logic             done
);

  localparam logic [IDX_W-1:0] J_LAST = IDX_W'(NWORDS - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    MUL    = 2'd1,
    STREAM = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t           state, state_nx;
  logic [WIDTH-1:0] t0_r, np_r;
  logic [WIDTH-1:0] m_next;

  // Product evaluated at WIDTH bits, so only the low word of t0*n' is formed.
  assign m_next = t0_r * np_r;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // Next state and decoded outputs; issue strobe follows stall combinationally.
  always_comb begin
    state_nx = state;
    busy     = 1'b0;
    m_valid  = 1'b0;
    en_out   = 1'b0;
    last     = 1'b0;
    done     = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nx = MUL;
      end
      MUL: begin
        busy     = 1'b1;
        state_nx = STREAM;
      end
      STREAM: begin
        busy    = 1'b1;
        m_valid = 1'b1;
        en_out  = ~stall;
        last    = ~stall & (j_idx == J_LAST);
        if (last) state_nx = DONE;
      end
      DONE: begin
        busy     = 1'b1;
        done     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Operand capture, m computation and word index sequencing.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      t0_r  <= '0;
      np_r  <= '0;
      m_out <= '0;
      j_idx <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            t0_r <= t0_in;
            np_r <= n_prime;
          end
        end
        MUL: begin
          m_out <= m_next;
          j_idx <= '0;
        end
        STREAM: begin
          if (en_out) begin
            if (j_idx == J_LAST) j_idx <= '0;
            else                 j_idx <= j_idx + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
